// File: rtl/harris_nms_extractor_if.sv
// Score-stream input and corner-record output handshake bundle.
// Latency: none (wires only).
// Backpressure: out_ready from the consumer; the input stream has no ready.
interface harris_nms_extractor_if #(
  parameter int SCORE_BITS = 33,
  parameter int COORD_BITS = 10
);
  logic                         in_valid;
  logic                         in_sof;
  logic signed [SCORE_BITS-1:0] in_score;
  logic                         out_valid;
  logic                         out_ready;
  logic        [COORD_BITS-1:0] out_x;
  logic        [COORD_BITS-1:0] out_y;
  logic signed [SCORE_BITS-1:0] out_score;

  // Score source and record consumer side.
  modport master (
    output in_valid, in_sof, in_score, out_ready,
    input  out_valid, out_x, out_y, out_score
  );

  // Extractor side.
  modport slave (
    input  in_valid, in_sof, in_score, out_ready,
    output out_valid, out_x, out_y, out_score
  );
endinterface

// File: rtl/harris_nms_extractor.sv
// Harris corner extractor: threshold plus 3x3 non-maximum suppression on a raster score stream.
// Latency: decision registered on the accepting edge, FIFO push one edge later; FWFT output.
// Backpressure: out_ready stalls only the output FIFO; a push into a full FIFO is dropped and counted.
module harris_nms_extractor #(
  parameter int SCORE_BITS     = 33,
  parameter int MAX_ROW_LENGTH = 640,
  parameter int COORD_BITS     = 10,
  parameter int FIFO_DEPTH     = 16,
  parameter int COUNT_BITS     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic        [COORD_BITS-1:0] r_row_length,
  input  logic        [COORD_BITS-1:0] r_num_rows,
  input  logic signed [SCORE_BITS-1:0] r_threshold,
  harris_nms_extractor_if.slave        bus,
  output logic                         out_frame_done,
  output logic        [COUNT_BITS-1:0] out_corner_count,
  output logic        [COUNT_BITS-1:0] out_drop_count
);
  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int LB_ADDR  = $clog2(MAX_ROW_LENGTH);
  localparam logic [COORD_BITS-1:0] C_ONE = COORD_BITS'(1);
  localparam logic [COORD_BITS-1:0] C_TWO = COORD_BITS'(2);
  localparam logic [PTR_BITS:0]     P_ONE = (PTR_BITS+1)'(1);
  localparam logic [COUNT_BITS-1:0] N_ONE = COUNT_BITS'(1);

  typedef struct packed {
    logic [COORD_BITS-1:0] x;
    logic [COORD_BITS-1:0] y;
    logic [SCORE_BITS-1:0] score;
  } rec_t;

  logic [COORD_BITS-1:0] x_cnt, y_cnt, cur_x, cur_y;
  logic                  sof_clr, row_end, last_row, eval, is_peak;
  logic [LB_ADDR-1:0]    lb_addr;
  logic signed [SCORE_BITS-1:0] lb1 [MAX_ROW_LENGTH];
  logic signed [SCORE_BITS-1:0] lb2 [MAX_ROW_LENGTH];
  logic signed [SCORE_BITS-1:0] lb1_rd, lb2_rd, centre;
  logic signed [SCORE_BITS-1:0] win [3][3];
  logic                  cand_vld, last_s1;
  rec_t                  cand, head;
  rec_t                  fifo_mem [FIFO_DEPTH];
  logic [PTR_BITS:0]     wr_ptr, rd_ptr;
  logic                  fifo_empty, fifo_full, pop, push, drop;

  // An accepted in_sof forces this sample to (0,0) whatever the counters say.
  assign sof_clr  = bus.in_valid && bus.in_sof;
  assign cur_x    = sof_clr ? '0 : x_cnt;
  assign cur_y    = sof_clr ? '0 : y_cnt;
  assign row_end  = (cur_x == r_row_length - C_ONE);
  assign last_row = (cur_y == r_num_rows - C_ONE);
  assign eval     = bus.in_valid && (cur_x >= C_TWO) && (cur_y >= C_TWO);

  // Raster position of the next sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (bus.in_valid) begin
      if (row_end) begin
        x_cnt <= '0;
        y_cnt <= last_row ? '0 : cur_y + C_ONE;
      end else begin
        x_cnt <= cur_x + C_ONE;
        y_cnt <= cur_y;
      end
    end
  end

  assign lb_addr = cur_x[LB_ADDR-1:0];
  assign lb1_rd  = lb1[lb_addr];
  assign lb2_rd  = lb2[lb_addr];

  // Line buffers: the column moves down one row (y-1 to y-2, new sample to y-1).
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      lb2[lb_addr] <= lb1_rd;
      lb1[lb_addr] <= bus.in_score;
    end
  end

  // 3x3 window shifts left by one column per accepted sample; row 0 is y-2, column 2 is x.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else if (bus.in_valid) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb2_rd;
      win[1][2] <= lb1_rd;
      win[2][2] <= bus.in_score;
    end
  end

  // Peak test on the post-shift window: strict against raster-earlier neighbours,
  // non-strict against raster-later ones, so a plateau yields only its first cell.
  always_comb begin
    centre  = win[1][2];
    is_peak = (centre > r_threshold)
           && (centre > win[0][1]) && (centre > win[0][2]) && (centre > lb2_rd)
           && (centre > win[1][1])
           && (centre >= lb1_rd)
           && (centre >= win[2][1]) && (centre >= win[2][2]) && (centre >= bus.in_score);
  end

  // Decision stage: single-cycle candidate and end-of-frame pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand_vld       <= 1'b0;
      cand           <= '0;
      last_s1        <= 1'b0;
      out_frame_done <= 1'b0;
    end else begin
      cand_vld       <= eval && is_peak;
      last_s1        <= bus.in_valid && row_end && last_row;
      out_frame_done <= last_s1;
      if (eval) cand <= '{x: cur_x - C_ONE, y: cur_y - C_ONE, score: centre};
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_BITS] != rd_ptr[PTR_BITS]) &&
                      (wr_ptr[PTR_BITS-1:0] == rd_ptr[PTR_BITS-1:0]);
  assign pop  = !fifo_empty && bus.out_ready;
  assign push = cand_vld && (!fifo_full || pop);
  assign drop = cand_vld && fifo_full && !pop;

  // FIFO storage; contents are only observed through the pointers.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_BITS-1:0]] <= cand;
  end

  // FIFO pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + P_ONE;
      if (pop)  rd_ptr <= rd_ptr + P_ONE;
    end
  end

  // Per-frame saturating counters; an accepted in_sof wins over a same-cycle increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_corner_count <= '0;
      out_drop_count   <= '0;
    end else if (sof_clr) begin
      out_corner_count <= '0;
      out_drop_count   <= '0;
    end else begin
      if (push && (out_corner_count != '1)) out_corner_count <= out_corner_count + N_ONE;
      if (drop && (out_drop_count != '1))   out_drop_count   <= out_drop_count + N_ONE;
    end
  end

  assign head          = fifo_mem[rd_ptr[PTR_BITS-1:0]];
  assign bus.out_valid = !fifo_empty;
  assign bus.out_x     = fifo_empty ? '0 : head.x;
  assign bus.out_y     = fifo_empty ? '0 : head.y;
  assign bus.out_score = fifo_empty ? '0 : $signed(head.score);
endmodule

// File: tb/tb_harris_nms_extractor.sv
// Bench for harris_nms_extractor: directed 8x6 frames, expected records queued at stimulus time,
// a forked monitor pops and compares every accepted output record.
module tb_harris_nms_extractor;
  localparam int SB = 33;
  localparam int CB = 10;
  localparam int NB = 16;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        [CB-1:0] r_row_length;
  logic        [CB-1:0] r_num_rows;
  logic signed [SB-1:0] r_threshold;
  logic                 out_frame_done;
  logic        [NB-1:0] out_corner_count;
  logic        [NB-1:0] out_drop_count;

  harris_nms_extractor_if #(.SCORE_BITS(SB), .COORD_BITS(CB)) bus ();

  harris_nms_extractor #(
    .SCORE_BITS(SB), .MAX_ROW_LENGTH(640), .COORD_BITS(CB),
    .FIFO_DEPTH(FD), .COUNT_BITS(NB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .r_row_length(r_row_length),
    .r_num_rows(r_num_rows),
    .r_threshold(r_threshold),
    .bus(bus),
    .out_frame_done(out_frame_done),
    .out_corner_count(out_corner_count),
    .out_drop_count(out_drop_count)
  );

  typedef struct { longint x; longint y; longint s; } exp_t;
  exp_t q[$];
  int   img [6][8];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   done0;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic clear_img(input int v);
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 8; x++)
        img[y][x] = v;
  endtask

  task automatic expect_rec(input int x, input int y, input int s);
    exp_t e;
    e.x = x; e.y = y; e.s = s;
    q.push_back(e);
  endtask

  // Sends the first 'limit' samples of the 8x6 frame in img; optional random idle cycles.
  task automatic send_frame(input int limit, input bit gaps, input bit lat);
    int n;
    bit armed;
    n = 0;
    armed = 1'b0;
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 8; x++) begin
        if (n < limit) begin
          if (gaps && ($urandom_range(0, 1) == 1)) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
          end
          bus.in_valid = 1'b1;
          bus.in_sof   = (x == 0 && y == 0);
          bus.in_score = SB'(img[y][x]);
          @(posedge clk); #1;
          n++;
          if (lat) begin
            if (armed) begin
              chk("push_visible_after_E+1", longint'(bus.out_valid), 1);
              armed = 1'b0;
            end
            if (x == 5 && y == 4) begin
              chk("no_push_at_E", longint'(bus.out_valid), 0);
              armed = 1'b1;
            end
          end
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    if (lat && n == 48) begin
      chk("frame_done_low_at_E", longint'(out_frame_done), 0);
      @(posedge clk); #1;
      chk("frame_done_at_E+1", longint'(out_frame_done), 1);
      @(posedge clk); #1;
      chk("frame_done_one_cycle", longint'(out_frame_done), 0);
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk(name, longint'(q.size()), 0);
  endtask

  initial begin
    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (out_frame_done) done_cnt++;
          if (reset && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_record: actual x=%0d y=%0d score=%0d required none",
                       bus.out_x, bus.out_y, bus.out_score);
            end else begin
              e = q.pop_front();
              chk("rec_x", longint'(bus.out_x), e.x);
              chk("rec_y", longint'(bus.out_y), e.y);
              chk("rec_score", longint'(bus.out_score), e.s);
            end
          end
        end
      end
      begin : watchdog
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench timeout");
      end
    join_none

    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_score  = '0;
    bus.out_ready = 1'b1;
    r_row_length  = 10'd8;
    r_num_rows    = 10'd6;
    r_threshold   = 33'sd100;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_x", longint'(bus.out_x), 0);
    chk("rst_out_y", longint'(bus.out_y), 0);
    chk("rst_out_score", longint'(bus.out_score), 0);
    chk("rst_corner_count", longint'(out_corner_count), 0);
    chk("rst_drop_count", longint'(out_drop_count), 0);
    chk("rst_frame_done", longint'(out_frame_done), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Single isolated peak, with latency and frame_done timing.
    clear_img(0);
    img[3][4] = 500;
    expect_rec(4, 3, 500);
    done0 = done_cnt;
    send_frame(48, 1'b0, 1'b1);
    drain("s1_all_records_seen");
    chk("s1_corner_count", longint'(out_corner_count), 1);
    chk("s1_drop_count", longint'(out_drop_count), 0);
    chk("s1_frame_done_pulses", longint'(done_cnt - done0), 1);

    // Two-cell plateau: only the raster-first cell survives.
    clear_img(0);
    img[2][3] = 300;
    img[2][4] = 300;
    expect_rec(3, 2, 300);
    send_frame(48, 1'b0, 1'b0);
    drain("s2_all_records_seen");
    chk("s2_corner_count", longint'(out_corner_count), 1);

    // Border peaks and a score equal to the threshold produce nothing.
    clear_img(0);
    img[3][0] = 1000;
    img[2][7] = 1000;
    img[2][2] = 100;
    send_frame(48, 1'b0, 1'b0);
    drain("s3_no_pending");
    chk("s3_corner_count", longint'(out_corner_count), 0);

    // Negative threshold and scores: signed comparison.
    r_threshold = -33'sd50;
    clear_img(-100);
    img[2][2] = -10;
    expect_rec(2, 2, -10);
    send_frame(48, 1'b0, 1'b0);
    drain("s_neg_all_records_seen");
    chk("s_neg_corner_count", longint'(out_corner_count), 1);
    r_threshold = 33'sd100;

    // Six peaks into a 4-deep FIFO with the consumer stalled.
    bus.out_ready = 1'b0;
    clear_img(0);
    img[1][1] = 200; img[1][3] = 210; img[1][5] = 220;
    img[3][1] = 230; img[3][3] = 240; img[3][5] = 250;
    expect_rec(1, 1, 200);
    expect_rec(3, 1, 210);
    expect_rec(5, 1, 220);
    expect_rec(1, 3, 230);
    send_frame(48, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("s4_out_valid_held", longint'(bus.out_valid), 1);
    chk("s4_head_x", longint'(bus.out_x), 1);
    chk("s4_head_y", longint'(bus.out_y), 1);
    chk("s4_corner_count", longint'(out_corner_count), 4);
    chk("s4_drop_count", longint'(out_drop_count), 2);
    bus.out_ready = 1'b1;
    drain("s4_all_records_seen");
    chk("s4_empty_after_pops", longint'(bus.out_valid), 0);

    // First frame again with random input gaps.
    clear_img(0);
    img[3][4] = 500;
    expect_rec(4, 3, 500);
    done0 = done_cnt;
    send_frame(48, 1'b1, 1'b0);
    drain("s5_all_records_seen");
    chk("s5_corner_count", longint'(out_corner_count), 1);
    chk("s5_frame_done_pulses", longint'(done_cnt - done0), 1);

    // Reset mid-frame with two records queued, then a clean frame.
    bus.out_ready = 1'b0;
    clear_img(0);
    img[1][1] = 200; img[1][3] = 210; img[1][5] = 220;
    img[3][1] = 230; img[3][3] = 240; img[3][5] = 250;
    send_frame(22, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("s6_queued_before_reset", longint'(bus.out_valid), 1);
    chk("s6_count_before_reset", longint'(out_corner_count), 2);
    reset = 1'b0;
    #1;
    chk("s6_out_valid_in_reset", longint'(bus.out_valid), 0);
    chk("s6_corner_count_in_reset", longint'(out_corner_count), 0);
    chk("s6_drop_count_in_reset", longint'(out_drop_count), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    clear_img(0);
    img[3][4] = 500;
    expect_rec(4, 3, 500);
    send_frame(48, 1'b0, 1'b0);
    drain("s6_all_records_seen");
    chk("s6_corner_count_after", longint'(out_corner_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
